// File: rtl/des_expand_mix_pipe.sv
// DES E-expansion (32->48) mixed with a round subkey, LANES wide, STAGES deep,
// with valid/ready backpressure. Define DES_EXPAND_SALT_EN to add crypt(3)-style salt swapping.
module des_expand_mix_pipe #(
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_r,
  input  logic [48*LANES-1:0]   in_key,
`ifdef DES_EXPAND_SALT_EN
  input  logic [12*LANES-1:0]   in_salt,
`endif
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [48*LANES-1:0]   out_x,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int XW = 48 * LANES;

  // Standard DES E table; R bit 31 is DES bit 1, out bit 47 is E bit 1.
  function automatic logic [47:0] e_expand(input logic [31:0] r);
    return {r[0], r[31:27], r[28:23], r[24:19], r[20:15],
            r[16:11], r[12:7], r[8:3], r[4:0], r[31]};
  endfunction

  logic [STAGES-1:0] v_q, v_d;
  logic [XW-1:0]     x_q   [STAGES];
  logic [XW-1:0]     x_d   [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic [STAGES-1:0] adv;
  logic [XW-1:0]     mix;

  always_comb begin : mix_comb
    logic [47:0] e_lane;
    mix    = '0;
    e_lane = '0;
    for (int l = 0; l < LANES; l++) begin
      e_lane = e_expand(in_r[32*l +: 32]);
`ifdef DES_EXPAND_SALT_EN
      // Salt must be applied to the beat it arrives with, before the key XOR.
      for (int i = 0; i < 12; i++) begin
        if (in_salt[12*l + i]) begin
          {e_lane[47-i], e_lane[23-i]} = {e_lane[23-i], e_lane[47-i]};
        end
      end
`endif
      mix[48*l +: 48] = e_lane ^ in_key[48*l +: 48];
    end
  end

  // A stage may load when it is empty or when everything downstream of it moves.
  always_comb begin : adv_chain
    logic acc;
    adv = '0;
    acc = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc    = acc | ~v_q[k];
      adv[k] = acc;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    v_d   = v_q;
    x_d   = x_q;
    tag_d = tag_q;
    if (adv[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        x_d[0]   = mix;
        tag_d[0] = in_tag;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          x_d[k]   = x_q[k-1];
          tag_d[k] = tag_q[k-1];
        end
      end
    end
  end

  // NOTE: non-blocking assignments only in sequential blocks, so all stages update from pre-edge values.
  // NOTE: data registers are reset (not just valids) because out_x/out_tag must read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k]   <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      x_q   <= x_d;
      tag_q <= tag_d;
    end
  end

  assign in_ready  = adv[0] & rst_n;
  assign out_valid = v_q[STAGES-1];
  assign out_x     = x_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_des_expand_mix_pipe.sv
// Self-checking bench for des_expand_mix_pipe: a table-driven E model plus an
// in-order scoreboard, run on a LANES=1/STAGES=2 and a LANES=3/STAGES=1 instance.
module tb_des_expand_mix_pipe;

  localparam int S1 = 2;
  localparam int E_TAB [48] = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,
                                8, 9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25,
                               24,25,26,27,28,29, 28,29,30,31,32, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // Instance 1: LANES=1, STAGES=2
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] in_r = '0;
  logic [47:0] in_key = '0, out_x;
  logic [11:0] in_salt = '0;
  logic [3:0]  in_tag = '0, out_tag;

  // Instance 2: LANES=3, STAGES=1
  logic         in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1;
  logic [95:0]  in_r2 = '0;
  logic [143:0] in_key2 = '0, out_x2;
  logic [35:0]  in_salt2 = '0;
  logic [3:0]   in_tag2 = '0, out_tag2;

  des_expand_mix_pipe #(.LANES(1), .STAGES(S1), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_key(in_key),
`ifdef DES_EXPAND_SALT_EN
    .in_salt(in_salt),
`endif
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_tag(out_tag));

  des_expand_mix_pipe #(.LANES(3), .STAGES(1), .TAG_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_r(in_r2), .in_key(in_key2),
`ifdef DES_EXPAND_SALT_EN
    .in_salt(in_salt2),
`endif
    .in_tag(in_tag2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_x(out_x2), .out_tag(out_tag2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // E built from the DES table in 1-based DES bit numbering.
  function automatic logic [47:0] model_e(input logic [31:0] r, input logic [47:0] k,
                                          input logic [11:0] s);
    logic [47:0] e;
    logic t;
    e = '0;
    for (int m = 1; m <= 48; m++) e[48-m] = r[32-E_TAB[m-1]];
    for (int i = 0; i < 12; i++) begin
      if (s[i]) begin
        t = e[47-i]; e[47-i] = e[23-i]; e[23-i] = t;
      end
    end
    return e ^ k;
  endfunction

  typedef struct {
    logic [47:0] x;
    logic [3:0]  tag;
  } beat_t;

  beat_t       exp_q[$];
  int          pops = 0;
  int          accepts = 0;
  logic        prev_stall = 1'b0;
  logic [47:0] prev_x = '0;
  logic [3:0]  prev_tag = '0;

  // Compare process: samples 2ns after each falling edge, i.e. the values the next rising edge sees.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_x", out_x, 48'h0);
      check("rst_out_tag", out_tag, 4'h0);
      check("rst_in_ready", in_ready, 1'b0);
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", in_ready, !(exp_q.size() == S1 && !out_ready));
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_x", out_x, prev_x);
        check("stall_tag", out_tag, prev_tag);
      end
      if (out_valid) begin
        check("out_has_beat", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          check("out_x", out_x, exp_q[0].x);
          check("out_tag", out_tag, exp_q[0].tag);
          if (out_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_x     = out_x;
      prev_tag   = out_tag;
      if (in_valid && in_ready) begin
        exp_q.push_back('{model_e(in_r, in_key, in_salt), in_tag});
        accepts++;
      end
    end
  end

  // Present one beat into an empty, free-flowing pipe and check its exact latency.
  task automatic single(input logic [31:0] r, input logic [47:0] k, input logic [3:0] tag,
                        input logic [47:0] x_exp);
    @(negedge clk);
    in_r = r; in_key = k; in_tag = tag; in_valid = 1'b1;
    #1 check("lat_accept", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("lat_early", out_valid, 1'b0);
    @(negedge clk);
    #1;
    check("lat_valid", out_valid, 1'b1);
    check("lat_x", out_x, x_exp);
    check("lat_tag", out_tag, tag);
  endtask

  // Called on a falling edge; returns on the falling edge after the beat was taken, in_valid still high.
  task automatic push(input logic [31:0] r, input logic [47:0] k, input logic [3:0] tag);
    bit done;
    done = 1'b0;
    in_r = r; in_key = k; in_tag = tag; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1 done = in_ready;
      @(negedge clk);
    end
    if (!done) check("push_timeout", done, 1'b1);
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    bit bp_done;
    int p0, p1, a0, a1;
    logic [143:0] exp2;

    // Model pinned against hand-computed values.
    check("pin_r1",   model_e(32'h00000001, 48'h0, 12'h0), 48'h800000000002);
    check("pin_r31",  model_e(32'h80000000, 48'h0, 12'h0), 48'h400000000001);
    check("pin_ones", model_e(32'hFFFFFFFF, 48'h0, 12'h0), 48'hFFFFFFFFFFFF);
    check("pin_key",  model_e(32'h0, 48'h123456789ABC, 12'h0), 48'h123456789ABC);
    check("pin_salt", model_e(32'h00000001, 48'h0, 12'h001), 48'h000000800002);

    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;
    #1 check("ready_after_release", in_ready, 1'b1);

    // E mapping and key mix.
    single(32'h00000001, 48'h0, 4'h5, 48'h800000000002);
    single(32'h80000000, 48'h0, 4'hA, 48'h400000000001);
    single(32'hFFFFFFFF, 48'h0, 4'h3, 48'hFFFFFFFFFFFF);
    single(32'h00000000, 48'h123456789ABC, 4'h9, 48'h123456789ABC);
    check("sbox1_addr", out_x[47:42], 6'h04);
    check("sbox8_addr", out_x[5:0], 6'h3C);

    // Backpressure: out_ready follows 1,0,0,1 while 8 tagged beats stream in.
    @(negedge clk);
    p0 = pops;
    bp_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 8; t++) push($urandom, {$urandom, $urandom}, 4'(t));
        in_valid = 1'b0;
        bp_done = 1'b1;
      end
      begin
        for (int ph = 0; !bp_done; ph++) begin
          out_ready = (ph % 4 == 0) || (ph % 4 == 3);
          @(negedge clk);
        end
      end
    join
    drain("bp_drain");
    check("bp_count", pops - p0, 8);

    // Fill the pipe, then push and pop together for 10 cycles.
    @(negedge clk);
    out_ready = 1'b0;
    push(32'h01234567, 48'h0000FFFF0000, 4'h1);
    push(32'h89ABCDEF, 48'hAAAA5555AAAA, 4'h2);
    in_valid = 1'b0;
    #1 check("full_in_ready", in_ready, 1'b0);
    @(negedge clk);
    p0 = pops; a0 = accepts;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_r = $urandom; in_key = {$urandom, $urandom}; in_tag = 4'(i); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    p1 = pops; a1 = accepts;
    check("full_pops", p1 - p0, 10);
    check("full_accepts", a1 - a0, 10);
    drain("full_drain");

    // Asynchronous reset with two beats in flight.
    @(negedge clk);
    out_ready = 1'b0;
    push(32'hDEADBEEF, 48'h0, 4'h7);
    push(32'hCAFEF00D, 48'h0, 4'h8);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_x", out_x, 48'h0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    #1 check("mid_rst_release_ready", in_ready, 1'b1);
    repeat (4) @(negedge clk);
    #1 check("no_stale_beat", out_valid, 1'b0);
    single(32'h00000001, 48'h0, 4'hE, 48'h800000000002);

    // Three lanes, single stage.
    @(negedge clk);
    in_r2   = {32'h00000000, 32'h80000000, 32'h00000001};
    in_key2 = {48'hFFFFFFFFFFFF, 48'h0, 48'h0};
`ifdef DES_EXPAND_SALT_EN
    in_salt2 = {12'h000, 12'h000, 12'h001};
    exp2 = {48'hFFFFFFFFFFFF, 48'h400000000001, 48'h000000800002};
`else
    exp2 = {48'hFFFFFFFFFFFF, 48'h400000000001, 48'h800000000002};
`endif
    in_tag2 = 4'hC;
    in_valid2 = 1'b1;
    #1;
    check("l3_in_ready", in_ready2, 1'b1);
    check("l3_early", out_valid2, 1'b0);
    @(negedge clk);
    in_valid2 = 1'b0;
    #1;
    check("l3_valid", out_valid2, 1'b1);
    check("l3_x_literal", out_x2, exp2);
    check("l3_x_model", out_x2, {model_e(in_r2[95:64], in_key2[143:96], in_salt2[35:24]),
                                 model_e(in_r2[63:32], in_key2[95:48],  in_salt2[23:12]),
                                 model_e(in_r2[31:0],  in_key2[47:0],   in_salt2[11:0])});
    check("l3_tag", out_tag2, 4'hC);
    @(negedge clk);
    #1 check("l3_popped", out_valid2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
